// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction sequencer: opcode map, halt word and
// fetch state encoding.
package instr_fetch_pkg;

   localparam logic [2:0] OP_JAL = 3'b000;
   localparam logic [2:0] OP_JR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_BEQ = 3'b011;
   localparam logic [2:0] OP_SW  = 3'b100;
   localparam logic [2:0] OP_LW  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_LA  = 3'b111;

   localparam logic [7:0] HALT_WORD = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FETCH = 2'b01,
      ST_ISSUE = 2'b10,
      ST_HALT  = 2'b11
   } fetch_state_e;

   // Only the all-ones word stops the sequencer; opcode 3'b111 alone does not.
   function automatic logic is_halt_word(input logic [7:0] word);
      return (word == HALT_WORD);
   endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction sequencer: holds the PC, fetches words over a req/valid handshake,
// issues each word to the decoder for one cycle and stops on the halt word.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
   input  logic            ck,
   input  logic            rst_n,
   input  logic            start,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic [7:0]      imem_rdata,
   input  logic            imem_valid,
   output logic [2:0]      op,
   output logic            LastBit,
   output logic [4:0]      operand,
   output logic            issue,
   input  logic            PCSrc,
   input  logic [PC_W-1:0] jump_target,
   output logic            halted,
   output logic [PC_W-1:0] pc
);

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [7:0]      ir_q, ir_d;
   logic            imem_req_q, imem_req_d;
   logic            issue_q, issue_d;
   logic            halted_q, halted_d;

   // Next-state, next-PC and registered strobe computation.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      imem_req_d = 1'b0;
      issue_d    = 1'b0;
      halted_d   = halted_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_FETCH;
               imem_req_d = 1'b1;
            end else begin
               state_d    = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (imem_valid) begin
               ir_d = imem_rdata;
               if (is_halt_word(imem_rdata)) begin
                  state_d  = ST_HALT;
                  halted_d = 1'b1;
               end else begin
                  state_d  = ST_ISSUE;
                  issue_d  = 1'b1;
               end
            end else begin
               // Keep the request up until memory answers.
               imem_req_d = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (PCSrc) begin
               pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
            end else begin
               pc_d = jump_target;
            end
            state_d    = ST_FETCH;
            imem_req_d = 1'b1;
         end
         ST_HALT: begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
         end
         default: begin
            state_d  = ST_IDLE;
            halted_d = 1'b0;
         end
      endcase
   end

   // State, PC, instruction register and output strobe flops.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         ir_q       <= 8'h00;
         imem_req_q <= 1'b0;
         issue_q    <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         imem_req_q <= imem_req_d;
         issue_q    <= issue_d;
         halted_q   <= halted_d;
      end
   end

   assign imem_req  = imem_req_q;
   assign imem_addr = pc_q;
   assign op        = ir_q[7:5];
   assign LastBit   = ir_q[0];
   assign operand   = ir_q[4:0];
   assign issue     = issue_q;
   assign halted    = halted_q;
   assign pc        = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: an instruction-level model plans every
// fetch/issue and a per-cycle compare process checks the DUT against it.
module tb_instr_fetch;

   logic       ck;
   logic       rst_n;
   logic       start;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic [7:0] imem_rdata;
   logic       imem_valid;
   logic [2:0] op;
   logic       LastBit;
   logic [4:0] operand;
   logic       issue;
   logic       PCSrc;
   logic [7:0] jump_target;
   logic       halted;
   logic [7:0] pc;

   instr_fetch #(.PC_W(8), .RESET_PC(8'h00)) dut (
      .ck(ck), .rst_n(rst_n), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_valid(imem_valid),
      .op(op), .LastBit(LastBit), .operand(operand), .issue(issue),
      .PCSrc(PCSrc), .jump_target(jump_target),
      .halted(halted), .pc(pc)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   int checks = 0;
   int errors = 0;
   int n_issue_seen = 0;
   int n_issue_exp = 0;

   logic [7:0] mem [256];
   logic [7:0] mdl_pc;
   logic       chk_en;
   logic       exp_req, exp_issue, exp_halted;
   logic [7:0] exp_pc, exp_ir;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   task automatic expect_idle();
      exp_req    = 1'b0;
      exp_issue  = 1'b0;
      exp_halted = 1'b0;
      exp_pc     = mdl_pc;
   endtask

   // Per-cycle comparison against the model, sampled on the falling edge.
   always @(negedge ck) begin
      if (issue === 1'b1) n_issue_seen++;
      if (chk_en) begin
         chk("imem_req", imem_req, exp_req);
         chk("issue", issue, exp_issue);
         chk("halted", halted, exp_halted);
         chk("pc", pc, exp_pc);
         if (exp_req) chk("imem_addr", imem_addr, exp_pc);
         if (!exp_halted) begin
            chk("op_operand", {op, operand}, exp_ir);
            chk("LastBit", LastBit, exp_ir[0]);
         end
      end
   end

   // Model of one instruction: w wait cycles, then issue (or halt) and PC update.
   task automatic run_instr(input int w, input bit src, input logic [7:0] jt);
      logic [7:0] word;
      word = mem[mdl_pc];
      for (int k = 0; k <= w + 1; k++) begin
         exp_req    = 1'b1;
         exp_issue  = 1'b0;
         exp_pc     = mdl_pc;
         start      = 1'($urandom);
         imem_valid = (k == w + 1);
         imem_rdata = (k == w + 1) ? word : 8'($urandom);
         tick();
      end
      imem_valid = 1'b0;
      if (word == 8'hFF) begin
         exp_halted = 1'b1;
         exp_req    = 1'b0;
         exp_issue  = 1'b0;
         exp_pc     = mdl_pc;
      end else begin
         exp_ir      = word;
         exp_issue   = 1'b1;
         exp_req     = 1'b0;
         exp_pc      = mdl_pc;
         n_issue_exp++;
         PCSrc       = src;
         jump_target = jt;
         imem_valid  = 1'($urandom);
         imem_rdata  = 8'($urandom);
         tick();
         mdl_pc      = src ? mdl_pc + 8'd1 : jt;
         imem_valid  = 1'b0;
         PCSrc       = 1'($urandom);
         jump_target = 8'($urandom);
         exp_issue   = 1'b0;
         exp_req     = 1'b1;
         exp_pc      = mdl_pc;
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 254));
      mem[0]      = 8'h41;
      mem[7]      = 8'h12;
      rst_n       = 1'b0;
      start       = 1'b0;
      imem_valid  = 1'b0;
      imem_rdata  = 8'h00;
      PCSrc       = 1'b0;
      jump_target = 8'h00;
      mdl_pc      = 8'h00;
      exp_ir      = 8'h00;
      expect_idle();
      chk_en      = 1'b1;
      tick();
      tick();
      chk("reset_req", imem_req, 1'b0);
      chk("reset_pc", pc, 8'h00);
      chk("reset_op", op, 3'b000);
      rst_n = 1'b1;
      imem_valid = 1'b1;
      imem_rdata = 8'h55;
      tick();
      imem_valid = 1'b0;
      tick();

      start = 1'b1;
      tick();
      start = 1'b0;
      run_instr(0, 1'b1, 8'h99);
      chk("dec_op", op, 3'b010);
      chk("dec_operand", operand, 5'h01);
      chk("dec_lastbit", LastBit, 1'b1);
      chk("seq_addr", imem_addr, 8'h01);
      run_instr(0, 1'b0, 8'h04);
      run_instr(0, 1'b0, 8'h20);
      chk("jump_addr", imem_addr, 8'h20);
      run_instr(3, 1'b0, 8'hFF);
      chk("wait_then_jump", imem_addr, 8'hFF);
      run_instr(1, 1'b1, 8'h33);
      chk("wrap_addr", imem_addr, 8'h00);

      for (int n = 0; n < 150; n++)
         run_instr(int'($urandom_range(0, 3)), 1'($urandom), 8'($urandom));

      if (mdl_pc == 8'd7) run_instr(0, 1'b0, 8'h00);
      mem[7] = 8'hFF;
      run_instr(0, 1'b0, 8'h07);
      run_instr(2, 1'b1, 8'h00);
      for (int i = 0; i < 6; i++) begin
         start = i[0];
         tick();
      end
      chk("halt_pc", pc, 8'h07);
      chk("halt_flag", halted, 1'b1);
      chk("halt_req", imem_req, 1'b0);

      rst_n  = 1'b0;
      start  = 1'b0;
      mdl_pc = 8'h00;
      exp_ir = 8'h00;
      expect_idle();
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_after_halt_pc", pc, 8'h00);
      chk("rst_after_halt_flag", halted, 1'b0);

      mem[7] = 8'h12;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      exp_req = 1'b1;
      tick();
      chk_en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_req_drop", imem_req, 1'b0);
      mdl_pc = 8'h00;
      exp_ir = 8'h00;
      expect_idle();
      tick();
      chk_en     = 1'b1;
      rst_n      = 1'b1;
      imem_valid = 1'b1;
      imem_rdata = 8'h41;
      tick();
      imem_valid = 1'b0;
      tick();
      tick();

      start = 1'b1;
      tick();
      start = 1'b0;
      run_instr(0, 1'b1, 8'h00);
      tick();
      chk("issue_count", n_issue_seen, n_issue_exp);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
